// File: rtl/vga_pkg.sv
// Shared types and default geometry for the framebuffer write path.
// The pixel record and writer state encoding are common to the FIFO and the writer.
package vga_pkg;

    localparam int DEF_H_RES  = 640;
    localparam int DEF_V_RES  = 480;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_ADDR_W = 19;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic       white;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } wr_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO of pixel_t records with a combinational read port,
// so the head entry can be popped and captured in the same clock edge.
module pixel_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  pixel_t                     din,
    input  logic                       pop,
    output pixel_t                     dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    pixel_t             r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    // A push into a full FIFO is refused even when a pop happens alongside it.
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_writer.sv
// Buffers incoming pixels, turns them into linear framebuffer writes and
// runs a full-screen clear sweep on request. Pop -> stage -> write pipeline.
module pixel_writer
    import vga_pkg::*;
#(
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [9:0]        in_x,
    input  logic [8:0]        in_y,
    input  logic              in_white,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_data,
    output logic [7:0]        drop_cnt
);

    localparam int               CNT_W  = $clog2(DEPTH) + 1;
    localparam logic [31:0]      H_U    = 32'(H_RES);
    localparam logic [31:0]      V_U    = 32'(V_RES);
    localparam logic [ADDR_W-1:0] H_A   = ADDR_W'(H_RES);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(H_RES * V_RES - 1);

    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;
    logic [CNT_W-1:0]   w_count_next;
    logic               w_push;
    logic               w_pop;
    logic               w_clear_acc;
    logic               w_in_range;
    logic [ADDR_W-1:0]  w_pix_addr;
    pixel_t             w_din;
    pixel_t             w_dout;

    wr_state_t          r_state;
    logic               r_clear_pend;
    logic [ADDR_W-1:0]  r_clr_addr;
    logic               r_stg_valid;
    pixel_t             r_stg;
    logic               r_fb_we;
    logic [ADDR_W-1:0]  r_fb_addr;
    logic               r_fb_data;
    logic               r_busy;
    logic [7:0]         r_drop;

    assign w_din    = '{x: in_x, y: in_y, white: in_white};
    assign in_ready = ~w_full;
    assign w_push   = in_valid & ~w_full;
    // Once a clear is pending no further entries leave the FIFO until the sweep ends.
    assign w_pop    = (r_state == DRAIN) & ~r_clear_pend & ~w_empty;

    assign w_clear_acc  = clear_req & ~r_clear_pend & ~r_busy & (r_state != CLEAR);
    assign w_count_next = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

    assign w_in_range = (32'(r_stg.x) < H_U) && (32'(r_stg.y) < V_U);
    assign w_pix_addr = ADDR_W'(r_stg.y) * H_A + ADDR_W'(r_stg.x);

    pixel_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .din   (w_din),
        .pop   (w_pop),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_clear_pend <= 1'b0;
            r_clr_addr   <= '0;
            r_stg_valid  <= 1'b0;
            r_stg        <= '0;
            r_fb_we      <= 1'b0;
            r_fb_addr    <= '0;
            r_fb_data    <= 1'b0;
            r_busy       <= 1'b0;
            r_drop       <= '0;
        end else begin
            r_fb_we     <= 1'b0;
            r_busy      <= (r_state == CLEAR);
            r_stg_valid <= w_pop;
            if (w_pop) begin
                r_stg <= w_dout;
            end
            if (w_clear_acc) begin
                r_clear_pend <= 1'b1;
            end

            // The stage slot never coincides with a clear write: pops stop a cycle before CLEAR.
            if (r_stg_valid) begin
                if (w_in_range) begin
                    r_fb_we   <= 1'b1;
                    r_fb_addr <= w_pix_addr;
                    r_fb_data <= r_stg.white;
                end else if (r_drop != 8'hFF) begin
                    r_drop <= r_drop + 8'd1;
                end
            end

            case (r_state)
                IDLE, DRAIN: begin
                    if (r_clear_pend) begin
                        r_state      <= CLEAR;
                        r_clr_addr   <= '0;
                        r_clear_pend <= 1'b0;
                    end else begin
                        r_state <= (w_count_next != '0) ? DRAIN : IDLE;
                    end
                end
                CLEAR: begin
                    r_fb_we    <= 1'b1;
                    r_fb_addr  <= r_clr_addr;
                    r_fb_data  <= 1'b0;
                    r_busy     <= 1'b1;
                    r_clr_addr <= r_clr_addr + ADDR_W'(1);
                    if (r_clr_addr == LAST_A) begin
                        r_state <= (w_count_next != '0) ? DRAIN : IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign fb_we      = r_fb_we;
    assign fb_addr    = r_fb_addr;
    assign fb_data    = r_fb_data;
    assign clear_busy = r_busy;
    assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_pixel_writer.sv
// Bench for pixel_writer: a full-size instance for addressing and drops, and a
// 4x3 instance for clear sweeps, both checked against a write-list model.
module tb_pixel_writer;

    logic clk;
    logic       v_rst   [2];
    logic       v_valid [2];
    logic [9:0] v_x     [2];
    logic [8:0] v_y     [2];
    logic       v_white [2];
    logic       v_clr   [2];

    logic        b_ready, b_busy, b_we, b_data;
    logic [18:0] b_addr;
    logic [7:0]  b_drop;
    logic        s_ready, s_busy, s_we, s_data;
    logic [3:0]  s_addr;
    logic [7:0]  s_drop;

    int n_tests = 0;
    int n_fail  = 0;

    int unsigned obs0[$];
    int unsigned obs1[$];
    int unsigned exp_q[$];
    int          s_busy_cyc;
    logic        saw_full;
    int          b_drop_exp;

    logic [9:0] fx [10];
    logic [8:0] fy [10];
    logic       fw [10];

    pixel_writer u_big (
        .clk        (clk),
        .reset      (v_rst[0]),
        .in_valid   (v_valid[0]),
        .in_ready   (b_ready),
        .in_x       (v_x[0]),
        .in_y       (v_y[0]),
        .in_white   (v_white[0]),
        .clear_req  (v_clr[0]),
        .clear_busy (b_busy),
        .fb_we      (b_we),
        .fb_addr    (b_addr),
        .fb_data    (b_data),
        .drop_cnt   (b_drop)
    );

    pixel_writer #(
        .H_RES  (4),
        .V_RES  (3),
        .DEPTH  (8),
        .ADDR_W (4)
    ) u_small (
        .clk        (clk),
        .reset      (v_rst[1]),
        .in_valid   (v_valid[1]),
        .in_ready   (s_ready),
        .in_x       (v_x[1]),
        .in_y       (v_y[1]),
        .in_white   (v_white[1]),
        .clear_req  (v_clr[1]),
        .clear_busy (s_busy),
        .fb_we      (s_we),
        .fb_addr    (s_addr),
        .fb_data    (s_data),
        .drop_cnt   (s_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned enc(input logic busy, input logic data, input int unsigned addr);
        return (int'(busy) << 21) | (int'(data) << 20) | (addr & 32'h000F_FFFF);
    endfunction

    // Write monitor: every strobe is logged with its data and the busy flag.
    always @(posedge clk) begin
        #1;
        if (b_we) obs0.push_back(enc(b_busy, b_data, 32'(b_addr)));
        if (s_we) obs1.push_back(enc(s_busy, s_data, 32'(s_addr)));
        if (s_busy) s_busy_cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end else begin
            $display("[TB] ok %s = %0d", tag, got);
        end
    endtask

    function automatic logic rdy(input int inst);
        return (inst == 0) ? b_ready : s_ready;
    endfunction

    // Presents one pixel and waits until it is accepted; valid stays high afterwards.
    task automatic send(input int inst, input logic [9:0] x, input logic [8:0] y, input logic w);
        int   n;
        logic r;
        v_valid[inst] = 1'b1;
        v_x[inst]     = x;
        v_y[inst]     = y;
        v_white[inst] = w;
        n = 0;
        do begin
            r = rdy(inst);
            if (!r) saw_full = 1'b1;
            @(negedge clk);
            n++;
        end while (!r && n < 100);
        if (!r) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        v_valid[0] = 1'b0;
        v_valid[1] = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clear(input int inst);
        v_clr[inst] = 1'b1;
        @(negedge clk);
        v_clr[inst] = 1'b0;
    endtask

    task automatic cmp_q(input int inst, input string tag);
        int unsigned got[$];
        int          n;
        if (inst == 0) got = obs0;
        else           got = obs1;
        check({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_w%0d", tag, i), got[i], exp_q[i]);
        end
        exp_q.delete();
        obs0.delete();
        obs1.delete();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            v_rst[i] = 1'b1; v_valid[i] = 1'b0; v_x[i] = '0;
            v_y[i] = '0; v_white[i] = 1'b0; v_clr[i] = 1'b0;
        end
        saw_full   = 1'b0;
        s_busy_cyc = 0;
        b_drop_exp = 0;
        repeat (3) @(negedge clk);

        check("rst_ready", 32'(b_ready), 32'd1);
        check("rst_we",    32'(b_we),    32'd0);
        check("rst_addr",  32'(b_addr),  32'd0);
        check("rst_data",  32'(b_data),  32'd0);
        check("rst_busy",  32'(b_busy),  32'd0);
        check("rst_drop",  32'(b_drop),  32'd0);
        check("rst_s_busy", 32'(s_busy), 32'd0);
        v_rst[0] = 1'b0;
        v_rst[1] = 1'b0;
        idle(2);
        obs0.delete(); obs1.delete();

        // Single pixel: write appears two edges after the push, for exactly one cycle.
        v_valid[0] = 1'b1; v_x[0] = 10'd3; v_y[0] = 9'd2; v_white[0] = 1'b1;
        @(negedge clk);
        v_valid[0] = 1'b0;
        check("single_e1_we", 32'(b_we), 32'd0);
        @(negedge clk);
        check("single_e2_we", 32'(b_we), 32'd0);
        @(negedge clk);
        check("single_we",   32'(b_we),   32'd1);
        check("single_addr", 32'(b_addr), 32'd1283);
        check("single_data", 32'(b_data), 32'd1);
        @(negedge clk);
        check("single_after_we",   32'(b_we),   32'd0);
        check("single_after_addr", 32'(b_addr), 32'd1283);
        idle(3);
        exp_q.push_back(enc(1'b0, 1'b1, 32'd1283));
        cmp_q(0, "single");

        // Out-of-range pixels are dropped; the far corner is the largest address.
        send(0, 10'd640, 9'd0,   1'b1);
        send(0, 10'd0,   9'd480, 1'b1);
        send(0, 10'd639, 9'd479, 1'b1);
        idle(6);
        b_drop_exp += 2;
        exp_q.push_back(enc(1'b0, 1'b1, 32'd307199));
        cmp_q(0, "oor");
        check("oor_drop", 32'(b_drop), 32'(b_drop_exp));

        // Burst of 10 with valid held high.
        for (int i = 0; i < 10; i++) begin
            logic [9:0] x; logic [8:0] y; logic w;
            x = 10'($urandom_range(0, 639));
            y = 9'($urandom_range(0, 479));
            w = 1'($urandom_range(0, 1));
            send(0, x, y, w);
            exp_q.push_back(enc(1'b0, w, int'(y) * 640 + int'(x)));
        end
        idle(6);
        cmp_q(0, "burst");

        // Randomised traffic with gaps and occasional out-of-range pixels.
        for (int i = 0; i < 150; i++) begin
            logic [9:0] x; logic [8:0] y; logic w;
            w = 1'($urandom_range(0, 1));
            x = 10'($urandom_range(0, 639));
            y = 9'($urandom_range(0, 479));
            if ($urandom_range(0, 9) == 0) x = 10'($urandom_range(640, 1023));
            if ($urandom_range(0, 9) == 0) y = 9'($urandom_range(480, 511));
            send(0, x, y, w);
            if (int'(x) < 640 && int'(y) < 480) exp_q.push_back(enc(1'b0, w, int'(y) * 640 + int'(x)));
            else b_drop_exp++;
            if ($urandom_range(0, 3) == 0) begin
                v_valid[0] = 1'b0;
                @(negedge clk);
            end
        end
        idle(8);
        cmp_q(0, "rand");
        check("rand_drop", 32'(b_drop), 32'(b_drop_exp > 255 ? 255 : b_drop_exp));

        // Drop counter saturation.
        for (int i = 0; i < 260; i++) send(0, 10'd700, 9'd5, 1'b1);
        idle(6);
        cmp_q(0, "sat");
        check("sat_drop", 32'(b_drop), 32'd255);

        // Small screen: clear sweep while pixels pile up in the FIFO; a second request mid-sweep is ignored.
        for (int i = 0; i < 10; i++) begin
            fx[i] = 10'($urandom_range(0, 3));
            fy[i] = 9'($urandom_range(0, 2));
            fw[i] = 1'($urandom_range(0, 1));
        end
        saw_full   = 1'b0;
        s_busy_cyc = 0;
        obs1.delete();
        pulse_clear(1);
        fork
            begin
                for (int i = 0; i < 10; i++) send(1, fx[i], fy[i], fw[i]);
                v_valid[1] = 1'b0;
            end
            begin
                repeat (4) @(negedge clk);
                check("fill_busy_mid", 32'(s_busy), 32'd1);
                v_clr[1] = 1'b1;
                @(negedge clk);
                v_clr[1] = 1'b0;
            end
        join
        idle(30);
        for (int a = 0; a < 12; a++) exp_q.push_back(enc(1'b1, 1'b0, a));
        for (int i = 0; i < 10; i++) exp_q.push_back(enc(1'b0, fw[i], int'(fy[i]) * 4 + int'(fx[i])));
        cmp_q(1, "fill");
        check("fill_ready_low", 32'(saw_full), 32'd1);
        check("fill_busy_cycles", 32'(s_busy_cyc), 32'd12);

        // Clear during drain: the in-flight pixel lands first, the rest after the sweep.
        s_busy_cyc = 0;
        for (int i = 0; i < 4; i++) begin
            fx[i] = 10'($urandom_range(0, 3));
            fy[i] = 9'($urandom_range(0, 2));
            fw[i] = 1'($urandom_range(0, 1));
        end
        send(1, fx[0], fy[0], fw[0]);
        v_clr[1] = 1'b1;
        send(1, fx[1], fy[1], fw[1]);
        v_clr[1] = 1'b0;
        send(1, fx[2], fy[2], fw[2]);
        send(1, fx[3], fy[3], fw[3]);
        idle(25);
        exp_q.push_back(enc(1'b0, fw[0], int'(fy[0]) * 4 + int'(fx[0])));
        for (int a = 0; a < 12; a++) exp_q.push_back(enc(1'b1, 1'b0, a));
        for (int i = 1; i < 4; i++) exp_q.push_back(enc(1'b0, fw[i], int'(fy[i]) * 4 + int'(fx[i])));
        cmp_q(1, "drainclr");
        check("drainclr_busy_cycles", 32'(s_busy_cyc), 32'd12);

        // Reset mid-clear aborts the sweep and flushes queued pixels.
        send(1, 10'd4, 9'd0, 1'b1);
        idle(5);
        check("small_drop", 32'(s_drop), 32'd1);
        cmp_q(1, "small_oor");
        pulse_clear(1);
        send(1, 10'd1, 9'd1, 1'b1);
        send(1, 10'd2, 9'd2, 1'b1);
        v_valid[1] = 1'b0;
        begin
            logic found;
            found = 1'b0;
            for (int k = 0; k < 40 && !found; k++) begin
                if (s_we && s_addr == 4'd5 && s_busy) found = 1'b1;
                else @(negedge clk);
            end
            check("rstmid_found_addr5", 32'(found), 32'd1);
        end
        v_rst[1] = 1'b1;
        @(negedge clk);
        v_rst[1] = 1'b0;
        check("rstmid_we",    32'(s_we),    32'd0);
        check("rstmid_busy",  32'(s_busy),  32'd0);
        check("rstmid_drop",  32'(s_drop),  32'd0);
        check("rstmid_ready", 32'(s_ready), 32'd1);
        obs1.delete();
        idle(20);
        cmp_q(1, "rstmid_flush");
        send(1, 10'd2, 9'd1, 1'b1);
        idle(6);
        exp_q.push_back(enc(1'b0, 1'b1, 32'd6));
        cmp_q(1, "rstmid_after");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
